// File: rtl/sound_pkg.sv
// Shared types, constants and the melody table for the piezo sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [1:0] SRC_SPIN  = 2'd0;
  localparam logic [1:0] SRC_WIN   = 2'd1;
  localparam logic [1:0] SRC_LOSE  = 2'd2;
  localparam logic [1:0] SRC_CLEAR = 2'd3;

  localparam int PTR_W     = 5;
  localparam int DIV_W     = 20;
  localparam int DUR_W     = 4;
  localparam int ENTRY_W   = DIV_W + DUR_W;
  localparam int CNT_W     = 26;
  localparam int ROM_DEPTH = 32;

  // A duration of zero terminates a melody.
  localparam logic [DUR_W-1:0] END_MARK = 4'd0;
  localparam logic [ENTRY_W-1:0] END_ENTRY = {20'd0, END_MARK};

  localparam logic [ENTRY_W-1:0] MELODY_TABLE [ROM_DEPTH] = '{
    {20'd22000, 4'd1},  {20'd18000, 4'd1},  {20'd15000, 4'd1},  {20'd18000, 4'd1},
    END_ENTRY,
    {20'd20000, 4'd4},  {20'd15000, 4'd4},  {20'd20000, 4'd4},  {20'd25000, 4'd4},
    END_ENTRY,
    {20'd50000, 4'd10},
    END_ENTRY,
    {20'd17000, 4'd6},  {20'd15000, 4'd6},  {20'd17000, 4'd6},  {20'd22000, 4'd12},
    END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY
  };

  function automatic logic [PTR_W-1:0] start_addr(input logic [1:0] src);
    case (src)
      SRC_SPIN:  start_addr = 5'd0;
      SRC_WIN:   start_addr = 5'd5;
      SRC_LOSE:  start_addr = 5'd10;
      default:   start_addr = 5'd12;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup: pointer to {divider, duration} entry.
module melody_rom
  import sound_pkg::*;
(
  input  logic [PTR_W-1:0]   addr,
  output logic [ENTRY_W-1:0] entry
);

  assign entry = MELODY_TABLE[addr];

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates the piezo between spin/win/lose/clear sources and steps the
// granted melody note by note, producing the buzzer divider.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 2_500_000,
  parameter int unsigned GAP_TICKS  = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic        cancel,
  output logic [31:0] tone_divider,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [3:0]  ack,
  output logic        done
);

  state_e             state_q, state_d;
  logic [3:0]         req_q;
  logic [3:1]         pend_q, pend_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [DUR_W-1:0]   unit_q, unit_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [31:0]        tone_divider_q, tone_divider_d;
  logic               busy_q, busy_d;
  logic [1:0]         active_id_q, active_id_d;
  logic [3:0]         ack_q, ack_d;
  logic               done_q, done_d;

  logic [ENTRY_W-1:0] rom_entry;
  logic [3:0]         rise;
  logic [3:0]         elig;
  logic [1:0]         best_id;
  logic               grant;
  logic [3:1]         grant_mask, active_mask;
  logic               is_end, spin_reload, play_end, gap_end;

  melody_rom u_rom (
    .addr  (ptr_q),
    .entry (rom_entry)
  );

  // Arbitration and per-state decisions shared by next-state and output logic.
  always_comb begin
    rise    = req & ~req_q;
    elig    = {pend_q, req[0]};
    best_id = SRC_SPIN;
    if (elig[3])      best_id = SRC_CLEAR;
    else if (elig[2]) best_id = SRC_LOSE;
    else if (elig[1]) best_id = SRC_WIN;

    grant = !cancel && (|elig) &&
            ((state_q == ST_IDLE) || (best_id > active_id_q));

    grant_mask  = '0;
    active_mask = '0;
    for (int k = 1; k < 4; k++) begin
      grant_mask[k]  = grant && (best_id == 2'(k));
      active_mask[k] = (state_q != ST_IDLE) && (active_id_q == 2'(k));
    end

    is_end      = (rom_entry[DUR_W-1:0] == END_MARK);
    spin_reload = is_end && (active_id_q == SRC_SPIN) && req[0];
    play_end    = (tick_q == CNT_W'(NOTE_TICKS - 1)) && (unit_q == dur_q - 4'd1);
    gap_end     = (gap_q == CNT_W'(GAP_TICKS - 1));
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tick_d  = '0;
    unit_d  = '0;
    gap_d   = '0;
    dur_d   = dur_q;
    div_d   = div_q;
    pend_d  = (pend_q | (rise[3:1] & ~active_mask)) & ~grant_mask;

    if (cancel) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      ptr_d   = '0;
    end else if (grant) begin
      state_d = ST_LOAD;
      ptr_d   = start_addr(best_id);
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (spin_reload) begin
            ptr_d = start_addr(SRC_SPIN);
          end else if (is_end) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PLAY;
            div_d   = rom_entry[ENTRY_W-1:DUR_W];
            dur_d   = rom_entry[DUR_W-1:0];
          end
        end
        ST_PLAY: begin
          if (play_end) begin
            state_d = ST_GAP;
          end else if (tick_q == CNT_W'(NOTE_TICKS - 1)) begin
            unit_d = unit_q + 4'd1;
          end else begin
            tick_d = tick_q + 1'b1;
            unit_d = unit_q;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state_d = ST_LOAD;
            ptr_d   = ptr_q + 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tone_divider_d = (state_d == ST_PLAY) ? {12'd0, div_d} : 32'd0;
    busy_d         = (state_d != ST_IDLE);
    ack_d          = grant ? (4'b0001 << best_id) : 4'b0000;
    done_d         = !cancel && !grant && (state_q == ST_LOAD) && is_end && !spin_reload;
    if (cancel || state_d == ST_IDLE) active_id_d = SRC_SPIN;
    else if (grant)                   active_id_d = best_id;
    else                              active_id_d = active_id_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      pend_q         <= '0;
      ptr_q          <= '0;
      tick_q         <= '0;
      gap_q          <= '0;
      unit_q         <= '0;
      dur_q          <= '0;
      div_q          <= '0;
      tone_divider_q <= '0;
      busy_q         <= 1'b0;
      active_id_q    <= '0;
      ack_q          <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req;
      pend_q         <= pend_d;
      ptr_q          <= ptr_d;
      tick_q         <= tick_d;
      gap_q          <= gap_d;
      unit_q         <= unit_d;
      dur_q          <= dur_d;
      div_q          <= div_d;
      tone_divider_q <= tone_divider_d;
      busy_q         <= busy_d;
      active_id_q    <= active_id_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
    end
  end

  assign tone_divider = tone_divider_q;
  assign busy         = busy_q;
  assign active_id    = active_id_q;
  assign ack          = ack_q;
  assign done         = done_q;

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Arbitrates the single piezo tone generator between the game's sound sources: spin ticks, win jingle, lose tone and stage-clear fanfare. Each source owns a fixed note sequence in a small ROM. The block plays the highest-priority pending sequence note by note and drives the `tone_divider` value into the existing square-wave buzzer stage. It sits between the FSM controller, which raises the requests, and the buzzer output stage.

## Interface
- `NOTE_TICKS`, default 2_500_000: clk cycles per duration unit (50 ms at 50 MHz).
- `GAP_TICKS`, default 250_000: silent cycles between notes (5 ms).
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `req` in 4: request per source.
  - Index 3 = clear, 2 = lose, 1 = win, 0 = spin.
  - Bit 0 is level-sensitive; bits 3..1 are rising-edge triggered.
- `cancel` in 1: abort playback and drop all pending requests.
- `tone_divider` out 32: divider for the buzzer stage; 0 = silent.
- `busy` out 1: high in LOAD, PLAY and GAP.
- `active_id` out 2: source currently granted; 0 when idle.
- `ack` out 4: one-cycle one-hot pulse when a source is granted.
- `done` out 1: one-cycle pulse when a sequence ends naturally.

## Operation
- **Pending register `pend[3:1]`.**
  - Set on a rising edge of `req[k]`, detected against a registered copy of `req`.
  - Cleared on grant or on `cancel`.
  - A rising edge of the currently active source is ignored: not latched, no ack.
- **Source 0** is eligible whenever `req[0]` is high; it has no pend bit.
- **Priority:** 3 > 2 > 1 > 0, fixed.
- **State IDLE.** If any source is eligible: grant the highest one, pulse `ack`, set `active_id`, load `ptr` with that melody's start address, go to LOAD.
- **State LOAD** (1 cycle). Read `rom[ptr]`:
  - End marker, source 0, and `req[0]` still high: reload the start address, stay in LOAD.
  - End marker, any other case: pulse `done`, go to IDLE.
  - Otherwise: latch the divider and duration, go to PLAY.
- **State PLAY.** Lasts exactly dur × `NOTE_TICKS` cycles with `tone_divider` = the note's divider. Then go to GAP.
- **State GAP.** Lasts exactly `GAP_TICKS` cycles with `tone_divider` = 0. Then `ptr`++ and go to LOAD.
- **Preemption.** In LOAD, PLAY or GAP, any eligible source with higher priority than `active_id` is granted immediately:
  - `ack` pulses; `ptr` loads the new start address; state goes to LOAD.
  - The preempted one-shot is discarded with no `done`.
  - A preempted spin resumes later if `req[0]` is still high.
- **`cancel`** overrides everything. Next edge: IDLE, `pend` = 0, `tone_divider` = 0, `active_id` = 0, no `done`. A `req` edge in the same cycle as `cancel` is dropped.
- **`tone_divider`** is 0 in IDLE, LOAD and GAP. It is the 20-bit ROM divider zero-extended to 32 bits.
- **ROM entry format:** {div[19:0], dur[3:0]}. dur = 0 is the end marker. 32 entries, 5-bit `ptr`.
- **Melodies** (divider/units):
  - spin: 22000/1, 18000/1, 15000/1, 18000/1
  - win: 20000/4, 15000/4, 20000/4, 25000/4
  - lose: 50000/10
  - clear: 17000/6, 15000/6, 17000/6, 22000/12

## Timing
- All outputs are registered.
- Reset values: `tone_divider` 0, `busy` 0, `active_id` 0, `ack` 0, `done` 0, `pend` 0, `req` history 0, `ptr` 0, state IDLE.
- `req[k]` rises in the cycle sampled at edge t:
  - `pend` is set after edge t.
  - Grant and `ack` after edge t+1.
  - LOAD in cycle t+2.
  - `tone_divider` is non-zero from cycle t+3.
- **Note-to-note period:** 1 (LOAD) + dur × `NOTE_TICKS` + `GAP_TICKS` cycles.
- `done` is asserted in the cycle after the LOAD that read the end marker, coincident with IDLE.
- **Counters:**
  - Tick counter runs 0..`NOTE_TICKS`-1 (26-bit).
  - Unit counter runs 0..dur-1.
  - Gap counter runs 0..`GAP_TICKS`-1.
  - All counters clear on every state entry.
- `rst_n` low mid-note: at the next edge all state returns to reset values.

## Structure
- Package `sound_pkg` holds:
  - state encoding;
  - source index constants;
  - `END_MARK`;
  - the 32×24 melody table and per-source start addresses.
- Sub-module `melody_rom` is a combinational lookup from `ptr` to entry, fed by the package table.

## Test plan
All scenarios use `NOTE_TICKS`=4 and `GAP_TICKS`=2.

- **Win sequence.** Pulse `req[1]` for 1 cycle.
  - `ack`=0010 two edges later.
  - `tone_divider` goes 20000 for 16 cycles, 0 for 2, then 15000, 20000, 25000.
  - `done` pulses once; `busy` falls.
- **Spin loop.** Hold `req[0]` high for 60 cycles.
  - The spin pattern repeats while `req[0]` is high.
  - After `req[0]` falls, the current note finishes; the next LOAD reads an end marker or re-checks the request, then `done` pulses.
- **Preemption.** Start lose, then pulse `req[3]` mid-PLAY.
  - `ack`=1000 on the following edge.
  - `tone_divider` becomes 17000 within 2 cycles.
  - No `done` for lose.
- **Simultaneous requests.** `req[2]` and `req[1]` rise in the same cycle.
  - Lose plays first; win stays pending and plays after lose's `done`.
- **Cancel.** Assert `cancel` during clear while win is pending.
  - Next cycle: `tone_divider`=0, `busy`=0, `pend`=0.
  - No `done`; nothing plays afterwards.
- **Reset.** Drive `rst_n` low mid-note for 1 cycle.
  - All outputs return to 0.
  - A new `req[1]` pulse restarts the win sequence from its first note.
